// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg: condition codes, flag bit indices and FSM encoding shared by the branch resolver
package branch_resolver_pkg;
  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_NE     = 3'b010;
  localparam logic [2:0] COND_LT     = 3'b011;
  localparam logic [2:0] COND_GT     = 3'b100;
  localparam logic [2:0] COND_LE     = 3'b101;
  localparam logic [2:0] COND_GE     = 3'b110;
  localparam logic [2:0] COND_NEVER  = 3'b111;
  localparam int FLAG_EQ = 0;
  localparam int FLAG_LT = 1;
  localparam int FLAG_GT = 2;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2
  } state_t;
endpackage

// File: rtl/branch_resolver_cond_eval.sv
// branch_resolver_cond_eval: combinational condition-code evaluation against a {gt,lt,eq} flag vector
module branch_resolver_cond_eval
  import branch_resolver_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic [2:0] flags_i,
  output logic       taken_o
);
  logic eq, lt, gt;
  assign eq = flags_i[FLAG_EQ];
  assign lt = flags_i[FLAG_LT];
  assign gt = flags_i[FLAG_GT];
  // Flags are taken literally, so illegal patterns still give a deterministic answer
  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_ALWAYS: taken_o = 1'b1;
      COND_EQ:     taken_o = eq;
      COND_NE:     taken_o = ~eq;
      COND_LT:     taken_o = lt;
      COND_GT:     taken_o = gt;
      COND_LE:     taken_o = lt | eq;
      COND_GE:     taken_o = gt | eq;
      COND_NEVER:  taken_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: captures comparator flags and resolves conditional branches into a PC-load pulse
// Optional BRANCH_STATS_EN adds saturating taken/not-taken counters.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmp_issue,
  input  logic              flag_valid,
  input  logic              flag_eq,
  input  logic              flag_lt,
  input  logic              flag_gt,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  output logic              res_valid,
  output logic              br_taken,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic [2:0]        flags_q
`ifdef BRANCH_STATS_EN
  ,
  output logic [7:0]        taken_cnt,
  output logic [7:0]        not_taken_cnt
`endif
);
  state_t            state_q, state_d;
  logic              pending_q, pending_d;
  logic [2:0]        cond_q, cond_d, flags_d;
  logic [ADDR_W-1:0] target_q, target_d, pc_target_q;
  logic              res_valid_q, br_taken_q, pc_load_q;
  logic              accept, taken_d, resolve_d;
  // Next-state values; the condition is evaluated on the flags that RESOLVE will see,
  // which lets flags arriving in the accept cycle bypass straight into the result
  always_comb begin
    accept    = br_valid & (state_q == ST_IDLE);
    flags_d   = flag_valid ? {flag_gt, flag_lt, flag_eq} : flags_q;
    pending_d = cmp_issue | (pending_q & ~flag_valid);
    cond_d    = accept ? br_cond : cond_q;
    target_d  = accept ? br_target : target_q;
    state_d   = (state_q == ST_IDLE) ?
                  (accept ? ((!pending_q || (flag_valid && !cmp_issue)) ? ST_RESOLVE : ST_WAIT) : ST_IDLE) :
                (state_q == ST_WAIT) ? (flag_valid ? ST_RESOLVE : ST_WAIT) : ST_IDLE;
    resolve_d = (state_d == ST_RESOLVE);
  end
  branch_resolver_cond_eval cond_eval (
    .cond_i  (cond_d),
    .flags_i (flags_d),
    .taken_o (taken_d)
  );
  // FSM with registered outputs computed one cycle ahead of RESOLVE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= 1'b0;
      flags_q     <= 3'b000;
      cond_q      <= COND_ALWAYS;
      target_q    <= '0;
      res_valid_q <= 1'b0;
      br_taken_q  <= 1'b0;
      pc_load_q   <= 1'b0;
      pc_target_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      flags_q     <= flags_d;
      cond_q      <= cond_d;
      target_q    <= target_d;
      res_valid_q <= resolve_d;
      pc_load_q   <= resolve_d & taken_d;
      if (resolve_d) br_taken_q <= taken_d;
      if (resolve_d && taken_d) pc_target_q <= target_d;
    end
  end
  assign br_ready  = (state_q == ST_IDLE);
  assign res_valid = res_valid_q;
  assign br_taken  = br_taken_q;
  assign pc_load   = pc_load_q;
  assign pc_target = pc_target_q;
`ifdef BRANCH_STATS_EN
  // Outcome counters saturate rather than wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt     <= 8'd0;
      not_taken_cnt <= 8'd0;
    end else if (res_valid_q) begin
      if (br_taken_q && taken_cnt != 8'hFF) taken_cnt <= taken_cnt + 8'd1;
      if (!br_taken_q && not_taken_cnt != 8'hFF) not_taken_cnt <= not_taken_cnt + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed and randomized checks of branch_resolver against a truth-table model
module tb_branch_resolver;
  import branch_resolver_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmp_issue = 1'b0, flag_valid = 1'b0;
  logic       flag_eq = 1'b0, flag_lt = 1'b0, flag_gt = 1'b0;
  logic       br_valid = 1'b0;
  logic [2:0] br_cond = 3'b000;
  logic [7:0] br_target = 8'h00;
  logic       br_ready, res_valid, br_taken, pc_load;
  logic [7:0] pc_target;
  logic [2:0] flags_q;
`ifdef BRANCH_STATS_EN
  logic [7:0] taken_cnt, not_taken_cnt;
`endif
  int errors = 0;
  int checks = 0;
  logic [2:0] m_flags = 3'b000;
  logic [7:0] m_target = 8'h00;
  logic       m_taken = 1'b0;

  branch_resolver #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmp_issue  (cmp_issue),
    .flag_valid (flag_valid),
    .flag_eq    (flag_eq),
    .flag_lt    (flag_lt),
    .flag_gt    (flag_gt),
    .br_valid   (br_valid),
    .br_ready   (br_ready),
    .br_cond    (br_cond),
    .br_target  (br_target),
    .res_valid  (res_valid),
    .br_taken   (br_taken),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .flags_q    (flags_q)
`ifdef BRANCH_STATS_EN
    ,
    .taken_cnt     (taken_cnt),
    .not_taken_cnt (not_taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Branch truth table written from the condition-code list, flags as named booleans
  function automatic logic model_taken(input logic [2:0] c, input logic [2:0] f);
    logic eq, lt, gt;
    eq = f[0];
    lt = f[1];
    gt = f[2];
    case (c)
      3'd0: return 1'b1;
      3'd1: return eq;
      3'd2: return !eq;
      3'd3: return lt;
      3'd4: return gt;
      3'd5: return lt || eq;
      3'd6: return gt || eq;
      default: return 1'b0;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_flags(input logic [2:0] f);
    flag_valid = 1'b1;
    {flag_gt, flag_lt, flag_eq} = f;
    cyc();
    flag_valid = 1'b0;
    m_flags = f;
    chk("flags_load", {29'd0, flags_q}, {29'd0, m_flags});
  endtask

  // Accept in cycle N, expect the resolution pulse in N+1 and idle again in N+2
  task automatic do_branch(input logic [2:0] c, input logic [7:0] t, input string tag);
    logic exp;
    exp = model_taken(c, m_flags);
    br_valid = 1'b1;
    br_cond = c;
    br_target = t;
    chk({tag, "_ready"}, {31'd0, br_ready}, 32'd1);
    cyc();
    br_valid = 1'b0;
    if (exp) m_target = t;
    m_taken = exp;
    chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd1);
    chk({tag, "_taken"}, {31'd0, br_taken}, {31'd0, exp});
    chk({tag, "_pc_load"}, {31'd0, pc_load}, {31'd0, exp});
    chk({tag, "_pc_target"}, {24'd0, pc_target}, {24'd0, m_target});
    chk({tag, "_ready_low"}, {31'd0, br_ready}, 32'd0);
    cyc();
    chk({tag, "_res_clear"}, {31'd0, res_valid}, 32'd0);
    chk({tag, "_pc_load_clear"}, {31'd0, pc_load}, 32'd0);
    chk({tag, "_taken_hold"}, {31'd0, br_taken}, {31'd0, m_taken});
    chk({tag, "_ready_back"}, {31'd0, br_ready}, 32'd1);
  endtask

  initial begin
    repeat (2) cyc();
    chk("rst_ready", {31'd0, br_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_taken", {31'd0, br_taken}, 32'd0);
    chk("rst_pc_load", {31'd0, pc_load}, 32'd0);
    chk("rst_pc_target", {24'd0, pc_target}, 32'd0);
    chk("rst_flags", {29'd0, flags_q}, 32'd0);
    rst_n = 1'b1;
    cyc();
    do_branch(COND_ALWAYS, 8'h22, "always_after_reset");
    do_branch(COND_NEVER, 8'h33, "never_after_reset");
    load_flags(3'b001);
    do_branch(COND_EQ, 8'h40, "eq_taken");
    load_flags(3'b010);
    do_branch(COND_GE, 8'h10, "ge_not_taken");

    // Outstanding compare: branch waits until the flags arrive
    cmp_issue = 1'b1;
    cyc();
    cmp_issue = 1'b0;
    br_valid = 1'b1;
    br_cond = COND_LT;
    br_target = 8'h77;
    cyc();
    br_valid = 1'b0;
    br_target = 8'h00;
    for (int i = 0; i < 3; i++) begin
      chk("wait_no_pulse", {31'd0, res_valid}, 32'd0);
      chk("wait_ready_low", {31'd0, br_ready}, 32'd0);
      cyc();
    end
    flag_valid = 1'b1;
    {flag_gt, flag_lt, flag_eq} = 3'b010;
    cyc();
    flag_valid = 1'b0;
    m_flags = 3'b010;
    m_target = 8'h77;
    chk("wait_res_valid", {31'd0, res_valid}, 32'd1);
    chk("wait_taken", {31'd0, br_taken}, 32'd1);
    chk("wait_pc_load", {31'd0, pc_load}, 32'd1);
    chk("wait_pc_target", {24'd0, pc_target}, 32'h77);
    cyc();
    chk("wait_done", {31'd0, res_valid}, 32'd0);

    // Bypass: flags land in the accept cycle of a pending compare
    cmp_issue = 1'b1;
    cyc();
    cmp_issue = 1'b0;
    flag_valid = 1'b1;
    {flag_gt, flag_lt, flag_eq} = 3'b100;
    br_valid = 1'b1;
    br_cond = COND_GT;
    br_target = 8'hFE;
    cyc();
    flag_valid = 1'b0;
    br_valid = 1'b0;
    m_flags = 3'b100;
    m_target = 8'hFE;
    chk("bypass_res_valid", {31'd0, res_valid}, 32'd1);
    chk("bypass_taken", {31'd0, br_taken}, 32'd1);
    chk("bypass_pc_target", {24'd0, pc_target}, 32'hFE);
    cyc();

    // Same, but a new compare is issued alongside the flags: branch must wait
    cmp_issue = 1'b1;
    cyc();
    flag_valid = 1'b1;
    {flag_gt, flag_lt, flag_eq} = 3'b100;
    br_valid = 1'b1;
    br_cond = COND_GT;
    br_target = 8'hF0;
    cyc();
    cmp_issue = 1'b0;
    flag_valid = 1'b0;
    br_valid = 1'b0;
    chk("bypass_issue_no_pulse", {31'd0, res_valid}, 32'd0);
    chk("bypass_issue_ready_low", {31'd0, br_ready}, 32'd0);
    chk("bypass_issue_flags", {29'd0, flags_q}, 32'd4);
    cyc();
    chk("bypass_issue_still_wait", {31'd0, res_valid}, 32'd0);
    flag_valid = 1'b1;
    {flag_gt, flag_lt, flag_eq} = 3'b100;
    cyc();
    flag_valid = 1'b0;
    m_target = 8'hF0;
    chk("bypass_issue_res_valid", {31'd0, res_valid}, 32'd1);
    chk("bypass_issue_pc_target", {24'd0, pc_target}, 32'hF0);
    cyc();

    // Flags arriving during RESOLVE do not disturb the in-flight evaluation
    load_flags(3'b001);
    br_valid = 1'b1;
    br_cond = COND_EQ;
    br_target = 8'h33;
    cyc();
    br_valid = 1'b0;
    flag_valid = 1'b1;
    {flag_gt, flag_lt, flag_eq} = 3'b010;
    m_target = 8'h33;
    chk("late_flags_taken", {31'd0, br_taken}, 32'd1);
    chk("late_flags_pc_load", {31'd0, pc_load}, 32'd1);
    cyc();
    flag_valid = 1'b0;
    m_flags = 3'b010;
    chk("late_flags_loaded", {29'd0, flags_q}, 32'd2);

    // Full truth table: every condition against each single flag
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 3; f++) begin
        load_flags(3'(1 << f));
        do_branch(3'(c), 8'($urandom_range(255)), $sformatf("tt_c%0d_f%0d", c, f));
      end

    // Random flag patterns, including illegal ones, with random conditions
    for (int i = 0; i < 40; i++) begin
      load_flags(3'($urandom_range(7)));
      do_branch(3'($urandom_range(7)), 8'($urandom_range(255)), "rand");
    end

    // Reset while waiting discards the branch
    cmp_issue = 1'b1;
    cyc();
    cmp_issue = 1'b0;
    br_valid = 1'b1;
    br_cond = COND_ALWAYS;
    br_target = 8'h5A;
    cyc();
    br_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_wait_ready", {31'd0, br_ready}, 32'd1);
    chk("rst_wait_flags", {29'd0, flags_q}, 32'd0);
    cyc();
    chk("rst_wait_no_pulse", {31'd0, res_valid}, 32'd0);
    rst_n = 1'b1;
    m_flags = 3'b000;
    m_target = 8'h00;
    m_taken = 1'b0;
    cyc();
    chk("rst_wait_no_pulse_after", {31'd0, res_valid}, 32'd0);
    chk("rst_wait_ready_after", {31'd0, br_ready}, 32'd1);
    chk("rst_wait_flags_after", {29'd0, flags_q}, 32'd0);
    chk("rst_wait_pc_target", {24'd0, pc_target}, 32'd0);
    do_branch(COND_ALWAYS, 8'h66, "after_rst_no_pending");

`ifdef BRANCH_STATS_EN
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    m_flags = 3'b000;
    m_target = 8'h00;
    cyc();
    chk("stats_rst_taken", {24'd0, taken_cnt}, 32'd0);
    do_branch(COND_NEVER, 8'h01, "stats_nt");
    chk("stats_not_taken", {24'd0, not_taken_cnt}, 32'd1);
    for (int i = 0; i < 300; i++) do_branch(COND_ALWAYS, 8'(i), "stats");
    chk("stats_taken_sat", {24'd0, taken_cnt}, 32'd255);
    chk("stats_not_taken_hold", {24'd0, not_taken_cnt}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
